// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants for the fetch/decode boundary.
package if_id_queue_pkg;
  localparam int INST_WIDTH    = 32;
  localparam int DEFAULT_DEPTH = 4;
  // Decode treats an all-zero instruction word as a bubble.
  localparam logic [INST_WIDTH-1:0] BUBBLE = 32'd0;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the prefetch queue.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = INST_WIDTH
);
  logic                   in_valid;
  logic [WIDTH-1:0]       in_pc;
  logic [WIDTH-1:0]       in_inst;
  logic                   in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_pc;
  logic [WIDTH-1:0]       out_inst;
  logic                   out_ready;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  // Pipeline side: fetch pushes, hazard unit drives out_ready, branch unit flushes.
  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/if_id_queue_wrap_counter.sv
// Modulo-MOD pointer counter with synchronous clear and async active-low reset.
module wrap_counter
  import if_id_queue_pkg::*;
#(
  parameter int MOD = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  output logic [$clog2(MOD)-1:0] value
);
  localparam int W = $clog2(MOD);

  // Clear wins over increment; wrap from MOD-1 back to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        value <= '0;
    else if (clr)    value <= '0;
    else if (inc)    value <= (value == W'(MOD - 1)) ? '0 : value + 1'b1;
  end
endmodule

// File: rtl/if_id_queue.sv
// Instruction prefetch queue between fetch and decode, with one-cycle flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = INST_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [CW-1:0]                count_q;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_pc, mem_inst;
  logic                         in_ready_w, out_valid_w, push, pop;

  // Ready/valid depend only on registered occupancy, never on out_ready.
  assign in_ready_w  = (count_q != CW'(DEPTH));
  assign out_valid_w = (count_q != '0);
  assign push        = q.in_valid & in_ready_w;
  assign pop         = out_valid_w & q.out_ready;

  wrap_counter #(.MOD(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (push),
    .clr   (q.flush),
    .value (wr_ptr)
  );

  wrap_counter #(.MOD(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop),
    .clr   (q.flush),
    .value (rd_ptr)
  );

  // Storage: zeroed on reset, untouched by flush; a push under flush is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_pc   <= '0;
      mem_inst <= '0;
    end else if (push && !q.flush) begin
      mem_pc[wr_ptr]   <= q.in_pc;
      mem_inst[wr_ptr] <= q.in_inst;
    end
  end

  // Occupancy: flush empties; push+pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               count_q <= '0;
    else if (q.flush)       count_q <= '0;
    else if (push && !pop)  count_q <= count_q + 1'b1;
    else if (pop && !push)  count_q <= count_q - 1'b1;
  end

  assign q.in_ready  = in_ready_w;
  assign q.out_valid = out_valid_w;
  assign q.count     = count_q;
  // Empty queue presents a bubble so decode sees a harmless instruction.
  assign q.out_pc    = out_valid_w ? mem_pc[rd_ptr]   : '0;
  assign q.out_inst  = out_valid_w ? mem_inst[rd_ptr] : WIDTH'(BUBBLE);
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based reference model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   run_cmp = 1'b0;
  ent_t mq[$];

  if_id_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain FIFO of entries with the queue's admission rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) mq.delete();
    else if (bus.flush) mq.delete();
    else begin
      bit can_push;
      bit do_pop;
      can_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop   = bus.out_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (can_push) mq.push_back('{pc: bus.in_pc, inst: bus.in_inst});
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_count", 64'(bus.count), 64'(mq.size()));
      chk("m_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("m_in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
      chk("m_out_pc", 64'(bus.out_pc), (mq.size() != 0) ? 64'(mq[0].pc) : 64'd0);
      chk("m_out_inst", 64'(bus.out_inst), (mq.size() != 0) ? 64'(mq[0].inst) : 64'd0);
    end
  end

  // One cycle of stimulus; returns #1 after the edge so outputs are settled.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 0; bus.flush = 0;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_cmp = 1'b1;

    // 1: streaming push/pop, occupancy holds at 1
    step(1, 32'd4, 32'h1004, 1, 0);
    chk("t1_first_pc", 64'(bus.out_pc), 64'd4);
    chk("t1_first_cnt", 64'(bus.count), 64'd1);
    for (int i = 2; i <= 4; i++) step(1, 32'(4 * i), 32'(32'h1000 + 4 * i), 1, 0);
    chk("t1_pc16", 64'(bus.out_pc), 64'd16);
    chk("t1_cnt", 64'(bus.count), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("t1_drained", 64'(bus.out_valid), 64'd0);

    // 2: fill with out_ready low
    for (int i = 1; i <= 4; i++) step(1, 32'(4 * i), 32'(32'hA000 + i), 0, 0);
    chk("t2_cnt4", 64'(bus.count), 64'd4);
    chk("t2_not_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_model_full", 64'(mq.size()), 64'd4);
    step(1, 32'd20, 32'hA005, 0, 0);
    chk("t2_refused_cnt", 64'(bus.count), 64'd4);
    chk("t2_head_pc", 64'(bus.out_pc), 64'd4);

    // 3: full + push + pop -> pop only, then order 8,12,16,20
    step(1, 32'd20, 32'hA005, 1, 0);
    chk("t3_cnt3", 64'(bus.count), 64'd3);
    chk("t3_ready", 64'(bus.in_ready), 64'd1);
    chk("t3_head8", 64'(bus.out_pc), 64'd8);
    step(1, 32'd20, 32'hA005, 1, 0);
    chk("t3_head12", 64'(bus.out_pc), 64'd12);
    step(0, 0, 0, 1, 0);
    chk("t3_head16", 64'(bus.out_pc), 64'd16);
    step(0, 0, 0, 1, 0);
    chk("t3_head20", 64'(bus.out_pc), 64'd20);
    chk("t3_inst20", 64'(bus.out_inst), 64'h0000A005);
    step(0, 0, 0, 1, 0);
    chk("t3_empty", 64'(bus.count), 64'd0);

    // 4: flush with coincident push
    for (int i = 0; i < 3; i++) step(1, 32'(40 + 4 * i), 32'(32'hB000 + i), 0, 0);
    chk("t4_cnt3", 64'(bus.count), 64'd3);
    step(1, 32'd100, 32'hDEAD, 1, 1);
    chk("t4_flush_cnt", 64'(bus.count), 64'd0);
    chk("t4_flush_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_flush_inst", 64'(bus.out_inst), 64'd0);
    chk("t4_flush_ready", 64'(bus.in_ready), 64'd1);
    step(1, 32'd204, 32'hC0DE, 0, 0);
    chk("t4_target_pc", 64'(bus.out_pc), 64'd204);
    chk("t4_target_cnt", 64'(bus.count), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("t4_drained", 64'(bus.out_valid), 64'd0);

    // 5: wrap-around at occupancy 2, inst = pc*3
    for (int k = 0; k < 2; k++) step(1, 32'(300 + 4 * k), 32'(3 * (300 + 4 * k)), 0, 0);
    for (int j = 0; j < 10; j++) begin
      step(1, 32'(300 + 4 * (j + 2)), 32'(3 * (300 + 4 * (j + 2))), 1, 0);
      chk("t5_pc", 64'(bus.out_pc), 64'(300 + 4 * (j + 1)));
      chk("t5_inst", 64'(bus.out_inst), 64'(3 * (300 + 4 * (j + 1))));
    end
    chk("t5_cnt2", 64'(bus.count), 64'd2);

    // 6: async reset mid-stream, checked without a clock edge
    #2;
    rst = 1'b0;
    #1;
    chk("t6_cnt", 64'(bus.count), 64'd0);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_pc", 64'(bus.out_pc), 64'd0);
    chk("t6_inst", 64'(bus.out_inst), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1, 32'd500, 32'h5005, 0, 0);
    chk("t6_resume_pc", 64'(bus.out_pc), 64'd500);
    step(0, 0, 0, 1, 0);
    chk("t6_resume_empty", 64'(bus.count), 64'd0);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
